gpio_cfg_ctrl: RTL and testbench

GPIO_CFG_CTRL -- requirements
Module: gpio_cfg_ctrl

---
 rtl/gpio_cfg_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_gpio_cfg_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_cfg_ctrl.sv
// rtl/gpio_cfg_ctrl.sv - PS GPIO strobe decoder that forwards config writes and fires run/delay triggers
// A synchronized write strobe either dispatches a cfg bus write or, for trigger addresses, a one-cycle pulse.
module gpio_cfg_ctrl #(
  parameter int                 ADDR_W   = 16,
  parameter int                 DATA_W   = 8,
  parameter int                 WCLK_BIT = 24,
  parameter logic [ADDR_W-1:0]  RUN_ADDR = 16'h0000,
  parameter logic [ADDR_W-1:0]  DEL_ADDR = 16'h0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       gpio_in,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [DATA_W-1:0] cfg_data,
  output logic              cfg_valid,
  input  logic              cfg_ready,
  input  logic              run_busy,
  output logic              run_trig,
  output logic              del_trig,
  output logic              run_active,
  output logic              err_drop,
  output logic [15:0]       wr_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_TRIG     = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_hist;
  logic [1:0]        r_live;
  logic              r_armed;
  logic [ADDR_W-1:0] r_cfg_addr;
  logic [DATA_W-1:0] r_cfg_data;
  logic              r_trig_run;
  logic              r_trig_del;
  logic              r_run_active;
  logic              r_busy_seen;
  logic              r_err_drop;
  logic [15:0]       r_wr_count;

  logic              w_rise;
  logic              w_is_trig;
  logic              w_run_trig;
  logic              w_del_trig;
  logic              w_cfg_valid;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_unused_gpio;

  assign w_addr        = gpio_in[ADDR_W-1:0];
  assign w_data        = gpio_in[ADDR_W +: DATA_W];
  assign w_unused_gpio = ^gpio_in;
  assign w_is_trig     = (w_addr == RUN_ADDR) || (w_addr == DEL_ADDR);

  // Only arm once sync2 has shown a genuine low sample, so a strobe already high at reset release is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
      r_live  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= gpio_in[WCLK_BIT];
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_live  <= {r_live[0], 1'b1};
      if (r_live[1] && !r_sync2) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_rise = r_sync2 & ~r_hist & r_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_next = w_is_trig ? S_TRIG : S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (cfg_ready) begin
          w_next = S_IDLE;
        end
      end
      S_TRIG:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cfg_valid = 1'b0;
    w_run_trig  = 1'b0;
    w_del_trig  = 1'b0;
    case (r_state)
      S_DISPATCH: w_cfg_valid = 1'b1;
      S_TRIG: begin
        w_run_trig = r_trig_run & ~r_run_active;
        w_del_trig = r_trig_del;
      end
      default: begin
        w_cfg_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_addr <= '0;
      r_cfg_data <= '0;
      r_trig_run <= 1'b0;
      r_trig_del <= 1'b0;
      r_wr_count <= 16'h0000;
      r_err_drop <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_rise) begin
        if (w_is_trig) begin
          r_trig_run <= (w_addr == RUN_ADDR) && w_data[0];
          r_trig_del <= (w_addr == DEL_ADDR) && w_data[0];
        end else begin
          r_cfg_addr <= w_addr;
          r_cfg_data <= w_data;
        end
      end
      if ((r_state == S_DISPATCH) && cfg_ready) begin
        r_wr_count <= r_wr_count + 16'h0001;
      end
      if ((w_rise && (r_state != S_IDLE)) ||
          ((r_state == S_TRIG) && r_trig_run && r_run_active)) begin
        r_err_drop <= 1'b1;
      end
    end
  end

  // A run ends only after busy has been observed high and then falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_active <= 1'b0;
      r_busy_seen  <= 1'b0;
    end else if (w_run_trig) begin
      r_run_active <= 1'b1;
      r_busy_seen  <= 1'b0;
    end else if (r_run_active) begin
      if (run_busy) begin
        r_busy_seen <= 1'b1;
      end else if (r_busy_seen) begin
        r_run_active <= 1'b0;
        r_busy_seen  <= 1'b0;
      end
    end
  end

  assign cfg_addr   = r_cfg_addr;
  assign cfg_data   = r_cfg_data;
  assign cfg_valid  = w_cfg_valid;
  assign run_trig   = w_run_trig;
  assign del_trig   = w_del_trig;
  assign run_active = r_run_active;
  assign err_drop   = r_err_drop;
  assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_gpio_cfg_ctrl.sv
// tb/tb_gpio_cfg_ctrl.sv - directed bench for gpio_cfg_ctrl
module tb_gpio_cfg_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] gpio_in;
  logic [15:0] cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        run_busy;
  logic        run_trig;
  logic        del_trig;
  logic        run_active;
  logic        err_drop;
  logic [15:0] wr_count;

  int n_cmp;
  int n_bad;
  int n_run;
  int n_del;

  gpio_cfg_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gpio_in    (gpio_in),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .run_busy   (run_busy),
    .run_trig   (run_trig),
    .del_trig   (del_trig),
    .run_active (run_active),
    .err_drop   (err_drop),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (run_trig) n_run = n_run + 1;
    if (del_trig) n_del = n_del + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    gpio_in = {7'b0, 1'b1, data, addr};
  endtask

  task automatic release_strobe();
    @(negedge clk);
    gpio_in = 32'h0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    logic stable;
    n_cmp = 0; n_bad = 0; n_run = 0; n_del = 0;
    gpio_in = 32'h0; cfg_ready = 1'b1; run_busy = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", cfg_valid, 0);
    chk("rst_addr", cfg_addr, 0);
    chk("rst_count", wr_count, 0);
    chk("rst_flags", {run_trig, del_trig, run_active, err_drop}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // basic write, ready high
    send(16'h0100, 8'h5A);
    repeat (2) @(posedge clk); #1;
    chk("t1_early", cfg_valid, 0);
    @(posedge clk); #1;
    chk("t1_valid", cfg_valid, 1);
    chk("t1_addr", cfg_addr, 32'h0100);
    chk("t1_data", cfg_data, 32'h5A);
    chk("t1_cnt0", wr_count, 0);
    @(posedge clk); #1;
    chk("t1_drop", cfg_valid, 0);
    chk("t1_cnt1", wr_count, 1);
    release_strobe();
    chk("t1_once", wr_count, 1);

    // backpressured write
    cfg_ready = 1'b0;
    send(16'h0002, 8'h11);
    repeat (3) @(posedge clk); #1;
    chk("t2_valid", cfg_valid, 1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!(cfg_valid === 1'b1 && cfg_addr === 16'h0002 && cfg_data === 8'h11)) stable = 1'b0;
    end
    chk("t2_hold", stable, 1);
    chk("t2_cnt_wait", wr_count, 1);
    @(negedge clk) cfg_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_done", cfg_valid, 0);
    chk("t2_cnt", wr_count, 2);
    release_strobe();

    // run trigger, then blocked second trigger
    send(16'h0000, 8'h01);
    repeat (3) @(posedge clk); #1;
    chk("t3_trig", run_trig, 1);
    chk("t3_nofwd", cfg_valid, 0);
    chk("t3_act0", run_active, 0);
    @(posedge clk); #1;
    chk("t3_pulse", run_trig, 0);
    chk("t3_act1", run_active, 1);
    release_strobe();
    @(negedge clk) run_busy = 1'b1;
    send(16'h0000, 8'h01);
    repeat (3) @(posedge clk); #1;
    chk("t3_blocked", run_trig, 0);
    @(posedge clk); #1;
    chk("t3_err", err_drop, 1);
    release_strobe();
    repeat (10) @(posedge clk); #1;
    chk("t3_still", run_active, 1);
    @(negedge clk) run_busy = 1'b0;
    @(posedge clk); #1;
    chk("t3_end", run_active, 0);
    chk("t3_nrun", n_run, 1);
    chk("t3_cnt", wr_count, 2);

    // delay trigger
    send(16'h0001, 8'h01);
    repeat (3) @(posedge clk); #1;
    chk("t4_trig", del_trig, 1);
    chk("t4_nofwd", cfg_valid, 0);
    @(posedge clk); #1;
    chk("t4_pulse", del_trig, 0);
    release_strobe();
    send(16'h0001, 8'h00);
    repeat (4) @(posedge clk);
    release_strobe();
    chk("t4_ndel", n_del, 1);
    chk("t4_cnt", wr_count, 2);

    // drop during dispatch
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("t5_rst", {err_drop, run_active}, 0);
    chk("t5_rstcnt", wr_count, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    cfg_ready = 1'b0;
    send(16'h0200, 8'h33);
    repeat (3) @(posedge clk); #1;
    chk("t5_valid", cfg_valid, 1);
    release_strobe();
    send(16'h0300, 8'h44);
    repeat (4) @(posedge clk); #1;
    chk("t5_err", err_drop, 1);
    chk("t5_addr", cfg_addr, 32'h0200);
    chk("t5_data", cfg_data, 32'h33);
    chk("t5_hold", cfg_valid, 1);
    @(negedge clk) cfg_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_done", cfg_valid, 0);
    chk("t5_cnt", wr_count, 1);
    release_strobe();
    chk("t5_single", wr_count, 1);

    // reset mid-dispatch with strobe still high at release
    cfg_ready = 1'b0;
    send(16'h0400, 8'h55);
    repeat (3) @(posedge clk); #1;
    chk("t6_valid", cfg_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async", {cfg_valid, run_trig, del_trig, run_active, err_drop}, 0);
    chk("t6_addr", cfg_addr, 0);
    chk("t6_cnt", wr_count, 0);
    @(negedge clk) begin rst_n = 1'b1; cfg_ready = 1'b1; end
    repeat (8) @(posedge clk); #1;
    chk("t6_ignore", {cfg_valid, cfg_addr}, 0);
    chk("t6_nocnt", wr_count, 0);
    release_strobe();
    send(16'h0500, 8'h66);
    repeat (3) @(posedge clk); #1;
    chk("t6_addr2", cfg_addr, 32'h0500);
    chk("t6_valid2", cfg_valid, 1);
    @(posedge clk); #1;
    chk("t6_cnt2", wr_count, 1);
    release_strobe();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
